// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter sharing the Sysbus memory port between instruction fetch (m0)
// and data memory (m1); one transaction at a time, held until its last beat.
module sysbus_arbiter #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13,
  parameter int BEATS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_reqcyc,
  input  logic [DATA_W-1:0] m0_req,
  input  logic [TAG_W-1:0]  m0_reqtag,
  output logic              m0_reqack,
  output logic              m0_respcyc,
  output logic [DATA_W-1:0] m0_resp,
  output logic [TAG_W-1:0]  m0_resptag,
  input  logic              m0_respack,
  input  logic              m1_reqcyc,
  input  logic [DATA_W-1:0] m1_req,
  input  logic [TAG_W-1:0]  m1_reqtag,
  output logic              m1_reqack,
  output logic              m1_respcyc,
  output logic [DATA_W-1:0] m1_resp,
  output logic [TAG_W-1:0]  m1_resptag,
  input  logic              m1_respack,
  output logic              bus_reqcyc,
  output logic [DATA_W-1:0] bus_req,
  output logic [TAG_W-1:0]  bus_reqtag,
  input  logic              bus_reqack,
  input  logic              bus_respcyc,
  input  logic [DATA_W-1:0] bus_resp,
  input  logic [TAG_W-1:0]  bus_resptag,
  output logic              bus_respack,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int BEAT_W = $clog2(BEATS) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] WDATA = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Handshakes: a beat moves on a cycle where its *cyc (valid) and matching *ack
  // (ready) are both high; valid is held until acked, and acks pass combinationally.

  logic [1:0]        state;
  logic              owner;
  logic              last_grant;
  logic [BEAT_W-1:0] beat;

  logic              own_reqcyc;
  logic [DATA_W-1:0] own_req;
  logic [TAG_W-1:0]  own_reqtag;
  logic              own_respack;
  logic              in_req;
  logic              in_resp;
  logic              grant;

  assign dbg_state = state;

  always_comb begin
    own_reqcyc  = owner ? m1_reqcyc  : m0_reqcyc;
    own_req     = owner ? m1_req     : m0_req;
    own_reqtag  = owner ? m1_reqtag  : m0_reqtag;
    own_respack = owner ? m1_respack : m0_respack;
    in_req      = (state == ADDR) || (state == WDATA);
    in_resp     = (state == RESP);
    // On a tie the port that did not win last time gets the bus.
    grant       = (m0_reqcyc && m1_reqcyc) ? !last_grant : m1_reqcyc;
  end

  always_comb begin
    bus_reqcyc  = in_req && own_reqcyc;
    bus_req     = in_req ? own_req : '0;
    bus_reqtag  = in_req ? own_reqtag : '0;
    bus_respack = in_resp && own_respack;

    m0_reqack   = in_req && !owner && bus_reqack;
    m1_reqack   = in_req &&  owner && bus_reqack;

    m0_respcyc  = in_resp && !owner && bus_respcyc;
    m0_resp     = (in_resp && !owner) ? bus_resp : '0;
    m0_resptag  = (in_resp && !owner) ? bus_resptag : '0;
    m1_respcyc  = in_resp &&  owner && bus_respcyc;
    m1_resp     = (in_resp &&  owner) ? bus_resp : '0;
    m1_resptag  = (in_resp &&  owner) ? bus_resptag : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      beat       <= '0;
      err        <= 1'b0;
    end else begin
      // A response beat outside RESP has no owner to go to; flag it and drop it.
      if (bus_respcyc && (state != RESP)) err <= 1'b1;

      case (state)
        IDLE: begin
          if (m0_reqcyc || m1_reqcyc) begin
            owner      <= grant;
            last_grant <= grant;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (bus_reqack) begin
            beat  <= '0;
            state <= own_reqtag[TAG_W-1] ? RESP : WDATA;
          end else if (!own_reqcyc) begin
            state <= IDLE;
          end
        end
        WDATA: begin
          if (bus_reqack) begin
            beat <= beat + BEAT_W'(1);
            if (beat == LAST_BEAT) state <= IDLE;
          end
        end
        RESP: begin
          if (bus_respcyc && own_respack) begin
            beat <= beat + BEAT_W'(1);
            if (beat == LAST_BEAT) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: bench-driven bus model, scoreboard queues for
// response beats per requester and for beats accepted by the bus.
module tb_sysbus_arbiter;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 13;
  localparam int BEATS  = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_WDATA = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [TAG_W-1:0] RD_TAG = 13'h1005;
  localparam logic [TAG_W-1:0] WR_TAG = 13'h0042;

  logic              clk;
  logic              reset;
  logic              m0_reqcyc, m1_reqcyc;
  logic [DATA_W-1:0] m0_req, m1_req;
  logic [TAG_W-1:0]  m0_reqtag, m1_reqtag;
  logic              m0_reqack, m1_reqack;
  logic              m0_respcyc, m1_respcyc;
  logic [DATA_W-1:0] m0_resp, m1_resp;
  logic [TAG_W-1:0]  m0_resptag, m1_resptag;
  logic              m0_respack, m1_respack;
  logic              bus_reqcyc;
  logic [DATA_W-1:0] bus_req;
  logic [TAG_W-1:0]  bus_reqtag;
  logic              bus_reqack;
  logic              bus_respcyc;
  logic [DATA_W-1:0] bus_resp;
  logic [TAG_W-1:0]  bus_resptag;
  logic              bus_respack;
  logic              err;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] m0_q[$];
  logic [DATA_W-1:0] m1_q[$];
  logic [DATA_W-1:0] breq_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  sysbus_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .m0_reqcyc(m0_reqcyc), .m0_req(m0_req), .m0_reqtag(m0_reqtag), .m0_reqack(m0_reqack),
    .m0_respcyc(m0_respcyc), .m0_resp(m0_resp), .m0_resptag(m0_resptag), .m0_respack(m0_respack),
    .m1_reqcyc(m1_reqcyc), .m1_req(m1_req), .m1_reqtag(m1_reqtag), .m1_reqack(m1_reqack),
    .m1_respcyc(m1_respcyc), .m1_resp(m1_resp), .m1_resptag(m1_resptag), .m1_respack(m1_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack), .err(err), .dbg_state(dbg_state)
  );

  // Clock / timeout
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on every accepted beat.
  always @(negedge clk) begin
    if (m0_respcyc && m0_respack) begin
      chk("m0_resp_expected", 64'(m0_q.size() != 0), 64'd1);
      if (m0_q.size() != 0) chk("m0_resp", m0_resp, m0_q.pop_front());
    end
    if (m1_respcyc && m1_respack) begin
      chk("m1_resp_expected", 64'(m1_q.size() != 0), 64'd1);
      if (m1_q.size() != 0) chk("m1_resp", m1_resp, m1_q.pop_front());
    end
    if (bus_reqcyc && bus_reqack) begin
      chk("bus_req_expected", 64'(breq_q.size() != 0), 64'd1);
      if (breq_q.size() != 0) chk("bus_req", bus_req, breq_q.pop_front());
    end
  end

  // Driver tasks
  task automatic set_req(input int p, input logic cyc, input logic [DATA_W-1:0] d,
                         input logic [TAG_W-1:0] t);
    if (p == 0) begin m0_reqcyc = cyc; m0_req = d; m0_reqtag = t; end
    else        begin m1_reqcyc = cyc; m1_req = d; m1_reqtag = t; end
  endtask

  task automatic set_respack(input int p, input logic v);
    if (p == 0) m0_respack = v;
    else        m1_respack = v;
  endtask

  // Called while port p owns the bus in ADDR; acks after 'waits' idle cycles.
  task automatic addr_phase(input int p, input logic [DATA_W-1:0] addr, input int waits,
                            input bit keep);
    breq_q.push_back(addr);
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      chk("addr_wait_reqcyc", bus_reqcyc, 1);
      chk("addr_wait_noack", (p == 0) ? m0_reqack : m1_reqack, 0);
      tick();
    end
    bus_reqack = 1'b1;
    @(negedge clk);
    chk("reqack_owner", (p == 0) ? m0_reqack : m1_reqack, 1);
    chk("reqack_other", (p == 0) ? m1_reqack : m0_reqack, 0);
    tick();
    bus_reqack = 1'b0;
    if (!keep) set_req(p, 1'b0, '0, '0);
  endtask

  // Delivers BEATS response beats base+i; stalls respack for stall_len cycles at beat stall_at.
  task automatic read_burst(input int p, input logic [DATA_W-1:0] base, input int stall_at,
                            input int stall_len);
    for (int i = 0; i < BEATS; i++) begin
      bus_respcyc = 1'b1;
      bus_resp    = base + DATA_W'(i);
      bus_resptag = RD_TAG;
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          set_respack(p, 1'b0);
          @(negedge clk);
          chk("stall_bus_respack", bus_respack, 0);
          chk("stall_state", dbg_state, S_RESP);
          tick();
        end
      end
      set_respack(p, 1'b1);
      if (p == 0) m0_q.push_back(base + DATA_W'(i));
      else        m1_q.push_back(base + DATA_W'(i));
      @(negedge clk);
      chk("burst_other_respcyc", (p == 0) ? m1_respcyc : m0_respcyc, 0);
      if (i == 0) chk("burst_resptag", (p == 0) ? m0_resptag : m1_resptag, RD_TAG);
      tick();
    end
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    set_respack(p, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    m0_respack = 1'b0; m1_respack = 1'b0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_err", err, 0);
    chk("rst_bus_reqcyc", bus_reqcyc, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_respack", bus_respack, 0);
    chk("rst_m0_respcyc", m0_respcyc, 0);

    // Tie after reset: m0 first, m1 after one IDLE cycle.
    tick();
    set_req(0, 1'b1, 64'h3000, RD_TAG);
    set_req(1, 1'b1, 64'h4000, RD_TAG);
    tick();
    @(negedge clk);
    chk("grant_latency_reqcyc", bus_reqcyc, 1);
    chk("grant_state", dbg_state, S_ADDR);
    tick();
    addr_phase(0, 64'h3000, 0, 0);
    read_burst(0, 64'h100, -1, 0);
    @(negedge clk);
    chk("tie_gap_state", dbg_state, S_IDLE);
    chk("tie_gap_bus_reqcyc", bus_reqcyc, 0);
    tick();
    addr_phase(1, 64'h4000, 0, 0);
    read_burst(1, 64'h200, -1, 0);

    // Tie again after m1 was last: m0 wins; backpressure mid-burst.
    set_req(0, 1'b1, 64'h5000, RD_TAG);
    set_req(1, 1'b1, 64'h6000, RD_TAG);
    tick();
    addr_phase(0, 64'h5000, 0, 0);
    read_burst(0, 64'h300, 3, 3);
    tick();
    addr_phase(1, 64'h6000, 0, 0);
    read_burst(1, 64'h380, -1, 0);

    // Single read from m0, bus acks after two cycles.
    set_req(0, 1'b1, 64'h1000, RD_TAG);
    tick();
    addr_phase(0, 64'h1000, 2, 0);
    read_burst(0, 64'h0, -1, 0);
    @(negedge clk);
    chk("single_read_idle", dbg_state, S_IDLE);

    // Tie with m0 last: m1 wins this time.
    tick();
    set_req(0, 1'b1, 64'h5100, RD_TAG);
    set_req(1, 1'b1, 64'h6100, RD_TAG);
    tick();
    addr_phase(1, 64'h6100, 0, 0);
    read_burst(1, 64'h500, -1, 0);
    tick();
    addr_phase(0, 64'h5100, 0, 0);
    read_burst(0, 64'h580, -1, 0);

    // Write from m1, acks every other cycle.
    set_req(1, 1'b1, 64'h2000, WR_TAG);
    tick();
    addr_phase(1, 64'h2000, 1, 1);
    for (int i = 0; i < BEATS; i++) begin
      set_req(1, 1'b1, 64'hA0 + 64'(i), WR_TAG);
      @(negedge clk);
      chk("wdata_pass", bus_req, 64'hA0 + 64'(i));
      chk("wdata_state", dbg_state, S_WDATA);
      chk("wdata_noack", m1_reqack, 0);
      tick();
      bus_reqack = 1'b1;
      breq_q.push_back(64'hA0 + 64'(i));
      @(negedge clk);
      chk("wdata_ack", m1_reqack, 1);
      tick();
      bus_reqack = 1'b0;
    end
    set_req(1, 1'b0, '0, '0);
    @(negedge clk);
    chk("write_idle", dbg_state, S_IDLE);
    chk("write_no_resp", m1_respcyc, 0);

    // Owner drops reqcyc before ack.
    tick();
    set_req(1, 1'b1, 64'h9000, WR_TAG);
    tick();
    @(negedge clk);
    chk("drop_addr_state", dbg_state, S_ADDR);
    set_req(1, 1'b0, '0, '0);
    tick();
    @(negedge clk);
    chk("drop_idle", dbg_state, S_IDLE);

    // Stray response beat in IDLE.
    tick();
    bus_respcyc = 1'b1;
    bus_resp    = 64'hDEAD;
    @(negedge clk);
    chk("stray_respack", bus_respack, 0);
    chk("stray_err_before", err, 0);
    tick();
    bus_respcyc = 1'b0;
    @(negedge clk);
    chk("stray_err_set", err, 1);
    tick();
    tick();
    @(negedge clk);
    chk("stray_err_sticky", err, 1);

    // Reset during beat 4 of a read.
    tick();
    set_req(0, 1'b1, 64'h7000, RD_TAG);
    tick();
    addr_phase(0, 64'h7000, 0, 0);
    set_respack(0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'(i);
      m0_q.push_back(64'(i));
      tick();
    end
    bus_resp = 64'd4;
    set_respack(0, 1'b0);
    reset = 1'b1;
    tick();
    bus_resp = 64'd5;
    set_respack(0, 1'b1);
    @(negedge clk);
    chk("midrst_state", dbg_state, S_IDLE);
    chk("midrst_m0_respcyc", m0_respcyc, 0);
    chk("midrst_m0_resp", m0_resp, 0);
    chk("midrst_bus_respack", bus_respack, 0);
    chk("midrst_bus_reqcyc", bus_reqcyc, 0);
    chk("midrst_err", err, 0);
    tick();
    reset = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp = '0;
    set_respack(0, 1'b0);
    @(negedge clk);
    chk("postrst_err", err, 0);

    // Served normally afterward.
    tick();
    set_req(0, 1'b1, 64'h8000, RD_TAG);
    tick();
    addr_phase(0, 64'h8000, 0, 0);
    read_burst(0, 64'h400, -1, 0);
    @(negedge clk);
    chk("final_idle", dbg_state, S_IDLE);
    chk("final_err", err, 0);

    chk("m0_q_drained", 64'(m0_q.size()), 0);
    chk("m1_q_drained", 64'(m1_q.size()), 0);
    chk("breq_q_drained", 64'(breq_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
